// File: rtl/arb_pkg.sv
// Shared definitions for the fixed-priority arbiter and its request sequencer.
//   N        : number of requesters
//   ID_W     : width of a requester index (clog2(N))
//   MAX_HOLD : default maximum BUSY cycles before a forced release
//   CNT_W    : hold counter width (MAX_HOLD < 2**CNT_W)
// Also provides the sequencer state type and one-hot helper functions.
package arb_pkg;

  localparam int unsigned N        = 8;
  localparam int unsigned ID_W     = 3;
  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  // Index of the set bit; 0 for an all-zero vector.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [N-1:0] oh);
    return (oh != '0) && ((oh & (oh - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Hold timer for the request sequencer.
// Ports:
//   i_clk     : rising-edge clock
//   i_rst_n   : asynchronous active-low reset
//   i_clr     : synchronous clear (priority over enable)
//   i_en      : count enable
//   o_expired : high while the count equals MAX_HOLD-1
module arb_hold_timer #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == CNT_W'(MAX_HOLD - 1));

endmodule

// File: rtl/arb_req_sequencer.sv
// Request sequencer wrapped around an external combinational fixed-priority arbiter.
// Captures request pulses into sticky pending bits, presents them to the arbiter,
// registers the winning one-hot grant and holds the resource until service completes
// or the hold timer forces a release.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_req_pulse      : per-client request pulses
//   o_arb_req        : pending vector to the arbiter
//   i_arb_gnt        : one-hot grant from the arbiter (used only in IDLE)
//   i_svc_done       : service-complete pulse from the owner
//   o_grant_valid    : one-cycle pulse when a grant is issued
//   o_grant_id       : index of the current owner
//   o_grant_onehot   : one-hot owner, zero in IDLE
//   o_busy           : resource owned (GRANT or BUSY)
//   o_timeout        : one-cycle pulse on forced release
//   o_overflow       : sticky, request pulse while already pending
//   o_gnt_err        : sticky, illegal grant seen with requests pending
module arb_req_sequencer #(
  parameter int unsigned N        = arb_pkg::N,
  parameter int unsigned ID_W     = arb_pkg::ID_W,
  parameter int unsigned MAX_HOLD = arb_pkg::MAX_HOLD,
  parameter int unsigned CNT_W    = arb_pkg::CNT_W
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_req_pulse,
  output logic [N-1:0]    o_arb_req,
  input  logic [N-1:0]    i_arb_gnt,
  input  logic            i_svc_done,
  output logic            o_grant_valid,
  output logic [ID_W-1:0] o_grant_id,
  output logic [N-1:0]    o_grant_onehot,
  output logic            o_busy,
  output logic            o_timeout,
  output logic [N-1:0]    o_overflow,
  output logic            o_gnt_err
);

  import arb_pkg::*;

  arb_state_e r_state, w_state_next;

  logic [N-1:0] r_pending;
  logic [N-1:0] r_owner;
  logic [N-1:0] r_overflow;
  logic         r_gnt_err;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_owner_next;
  logic         w_gnt_err_set;
  logic         w_expired;
  logic         w_tmr_clr;
  logic         w_tmr_en;

  assign w_tmr_clr = (r_state == GRANT);
  assign w_tmr_en  = (r_state == BUSY);

  arb_hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_next  = r_state;
    w_clr         = '0;
    w_owner_next  = r_owner;
    w_gnt_err_set = 1'b0;
    o_timeout     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pending != '0) begin
          // Accept only a single grant bit that names a client actually pending.
          if (is_onehot(i_arb_gnt) && ((i_arb_gnt & ~r_pending) == '0)) begin
            w_clr        = i_arb_gnt;
            w_owner_next = i_arb_gnt;
            w_state_next = GRANT;
          end else begin
            w_gnt_err_set = 1'b1;
          end
        end
      end
      GRANT: begin
        w_state_next = BUSY;
      end
      BUSY: begin
        // Service completion beats a coincident expiry.
        if (i_svc_done) begin
          w_state_next = IDLE;
          w_owner_next = '0;
        end else if (w_expired) begin
          o_timeout    = 1'b1;
          w_state_next = IDLE;
          w_owner_next = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_owner_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_owner    <= '0;
      r_overflow <= '0;
      r_gnt_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      // A new pulse wins over a same-cycle clear so no request is lost.
      r_pending  <= (r_pending & ~w_clr) | i_req_pulse;
      r_owner    <= w_owner_next;
      r_overflow <= r_overflow | (i_req_pulse & r_pending);
      r_gnt_err  <= r_gnt_err | w_gnt_err_set;
    end
  end

  assign o_arb_req      = r_pending;
  assign o_grant_valid  = (r_state == GRANT);
  assign o_busy         = (r_state == GRANT) || (r_state == BUSY);
  assign o_grant_onehot = r_owner;
  assign o_grant_id     = onehot_to_idx(r_owner);
  assign o_overflow     = r_overflow;
  assign o_gnt_err      = r_gnt_err;

endmodule

// File: tb/tb_arb_req_sequencer.sv
// Scoreboard bench for arb_req_sequencer. A behavioural priority arbiter (lowest set
// bit wins) closes the loop; a reference model pushes per-cycle expectations and
// expected grant owners into queues that a negedge monitor pops and compares.
module tb_arb_req_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_pulse;
  logic       svc;
  logic       force_en;
  logic [7:0] force_val;

  logic [7:0] arb_req;
  logic [7:0] arb_gnt;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic [7:0] grant_onehot;
  logic       busy;
  logic       timeout;
  logic [7:0] overflow;
  logic       gnt_err;

  always #5 clk = ~clk;

  // Stand-in fixed-priority arbiter, with an override to inject illegal grants.
  assign arb_gnt = force_en ? force_val : (arb_req & (~arb_req + 8'd1));

  arb_req_sequencer u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_pulse    (req_pulse),
    .o_arb_req      (arb_req),
    .i_arb_gnt      (arb_gnt),
    .i_svc_done     (svc),
    .o_grant_valid  (grant_valid),
    .o_grant_id     (grant_id),
    .o_grant_onehot (grant_onehot),
    .o_busy         (busy),
    .o_timeout      (timeout),
    .o_overflow     (overflow),
    .o_gnt_err      (gnt_err)
  );

  typedef struct packed {
    logic [7:0] arb_req;
    logic       busy;
    logic       gv;
    logic       to;
    logic [7:0] oh;
    logic [7:0] ovf;
    logic       err;
  } exp_t;

  exp_t cyc_q[$];
  int   grant_q[$];
  int   seen_ids[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  // Reference model: owner index (-1 when free) and cycles since the grant.
  logic [7:0] m_pend;
  logic [7:0] m_ovf;
  logic       m_err;
  int         m_owner;
  int         m_age;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lowest_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int ones(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_ovf   = '0;
    m_err   = 1'b0;
    m_owner = -1;
    m_age   = 0;
    cyc_q.delete();
    grant_q.delete();
  endtask

  task automatic model_cycle(input logic [7:0] pulse, input logic s, input logic fen,
                             input logic [7:0] fval);
    exp_t       e;
    logic [7:0] gnt;
    logic [7:0] clr;
    e.arb_req = m_pend;
    e.busy    = (m_owner >= 0);
    e.gv      = (m_owner >= 0) && (m_age == 0);
    e.to      = 1'b0;
    e.oh      = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    e.ovf     = m_ovf;
    e.err     = m_err;
    clr       = '0;
    if (m_owner < 0) begin
      if (m_pend != 0) begin
        gnt = fen ? fval : (8'd1 << lowest_idx(m_pend));
        if (ones(gnt) == 1 && (gnt & ~m_pend) == 0) begin
          m_owner = lowest_idx(gnt);
          m_age   = 0;
          clr     = gnt;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_age == 0) begin
      grant_q.push_back(m_owner);
      m_age = 1;
    end else if (s) begin
      m_owner = -1;
    end else if (m_age == 16) begin
      e.to    = 1'b1;
      m_owner = -1;
    end else begin
      m_age++;
    end
    m_ovf  = m_ovf | (pulse & m_pend);
    m_pend = (m_pend & ~clr) | pulse;
    cyc_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] pulse, input logic s, input logic fen,
                      input logic [7:0] fval);
    @(posedge clk);
    #1;
    req_pulse = pulse;
    svc       = s;
    force_en  = fen;
    force_val = fval;
    model_cycle(pulse, s, fen, fval);
    mon_en = 1'b1;
  endtask

  task automatic flush();
    int k;
    k = 0;
    while ((m_owner >= 0 || m_pend != 0) && k < 200) begin
      step(8'd0, (m_owner >= 0 && m_age >= 1), 1'b0, 8'd0);
      k++;
    end
    if (m_owner >= 0 || m_pend != 0) begin
      n_checks++;
      $display("FAIL flush_budget: got busy expected idle at %0t", $time);
    end
  endtask

  task automatic reset_now();
    @(posedge clk);
    #1;
    mon_en    = 1'b0;
    req_pulse = '0;
    svc       = 1'b0;
    force_en  = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_onehot", {24'd0, grant_onehot}, 32'd0);
    chk("rst_mid_arb_req", {24'd0, arb_req}, 32'd0);
    chk("rst_mid_timeout", {31'd0, timeout}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  exp_t mon_e;
  int   mon_id;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc_q.size() == 0) begin
        n_checks++;
        $display("FAIL cyc_q_underflow: got empty expected entry at %0t", $time);
      end else begin
        mon_e = cyc_q.pop_front();
        chk("arb_req", {24'd0, arb_req}, {24'd0, mon_e.arb_req});
        chk("busy", {31'd0, busy}, {31'd0, mon_e.busy});
        chk("grant_valid", {31'd0, grant_valid}, {31'd0, mon_e.gv});
        chk("timeout", {31'd0, timeout}, {31'd0, mon_e.to});
        chk("grant_onehot", {24'd0, grant_onehot}, {24'd0, mon_e.oh});
        chk("overflow", {24'd0, overflow}, {24'd0, mon_e.ovf});
        chk("gnt_err", {31'd0, gnt_err}, {31'd0, mon_e.err});
      end
      if (grant_valid) begin
        if (grant_q.size() == 0) begin
          n_checks++;
          $display("FAIL grant_unexpected: got id %0d expected none at %0t", grant_id, $time);
        end else begin
          mon_id = grant_q.pop_front();
          chk("grant_id", {29'd0, grant_id}, mon_id);
        end
        seen_ids.push_back(int'(grant_id));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g0;
    int n5;
    logic [7:0] p;
    logic [7:0] fv;
    req_pulse = '0;
    svc       = 1'b0;
    force_en  = 1'b0;
    force_val = '0;
    rst_n     = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_arb_req", {24'd0, arb_req}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_grant_valid", {31'd0, grant_valid}, 32'd0);
    chk("reset_grant_id", {29'd0, grant_id}, 32'd0);
    chk("reset_onehot", {24'd0, grant_onehot}, 32'd0);
    chk("reset_overflow", {24'd0, overflow}, 32'd0);
    chk("reset_gnt_err", {31'd0, gnt_err}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: pulse, arb_req next cycle, grant the cycle after.
    step(8'h80, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    chk("t1_arb_req", {24'd0, arb_req}, 32'h80);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    chk("t1_grant_valid", {31'd0, grant_valid}, 32'd1);
    chk("t1_grant_id", {29'd0, grant_id}, 32'd7);
    chk("t1_onehot", {24'd0, grant_onehot}, 32'h80);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b1, 1'b0, 8'd0);
    chk("t1_busy_held", {31'd0, busy}, 32'd1);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    chk("t1_released", {31'd0, busy}, 32'd0);

    // All clients at once are served in priority order.
    g0 = seen_ids.size();
    step(8'hFF, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 120 && (m_owner >= 0 || m_pend != 0); k++)
      step(8'h00, (m_owner >= 0 && m_age == 2), 1'b0, 8'd0);
    @(negedge clk);
    #1;
    chk("t2_grant_count", seen_ids.size() - g0, 32'd8);
    for (int i = 0; i < 8; i++)
      if (g0 + i < seen_ids.size()) chk("t2_grant_order", seen_ids[g0 + i], i);
    chk("t2_arb_req_empty", {24'd0, arb_req}, 32'd0);

    // Repeated pulses on a pending client set overflow but yield one grant.
    g0 = seen_ids.size();
    step(8'h01, 1'b0, 1'b0, 8'd0);
    step(8'h20, 1'b0, 1'b0, 8'd0);
    step(8'h20, 1'b0, 1'b0, 8'd0);
    step(8'h20, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    chk("t4_overflow", {24'd0, overflow}, 32'h20);
    flush();
    @(negedge clk);
    #1;
    n5 = 0;
    for (int i = g0; i < seen_ids.size(); i++) if (seen_ids[i] == 5) n5++;
    chk("t4_single_grant5", n5, 32'd1);

    // Illegal two-hot grant: error flagged, no grant, stays idle.
    step(8'h03, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b1, 8'h03);
    step(8'h00, 1'b0, 1'b1, 8'h03);
    chk("t5_gnt_err", {31'd0, gnt_err}, 32'd1);
    chk("t5_no_grant", {31'd0, grant_valid}, 32'd0);
    chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_pending", {24'd0, arb_req}, 32'h03);
    flush();

    // Withheld service: forced release after 16 BUSY cycles.
    step(8'h08, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    chk("t3_grant_id", {29'd0, grant_id}, 32'd3);
    for (int i = 0; i < 16; i++) begin
      step(8'h00, 1'b0, 1'b0, 8'd0);
      #1;
      chk("t3_timeout", {31'd0, timeout}, (i == 15) ? 32'd1 : 32'd0);
    end
    step(8'h00, 1'b0, 1'b0, 8'd0);
    chk("t3_busy_dropped", {31'd0, busy}, 32'd0);
    chk("t3_pending3_clear", {31'd0, arb_req[3]}, 32'd0);

    // Reset in the middle of BUSY, then a fresh request is served normally.
    step(8'h04, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    chk("t6_owner", {24'd0, grant_onehot}, 32'h04);
    reset_now();
    step(8'h04, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    step(8'h00, 1'b0, 1'b0, 8'd0);
    chk("t6_regrant_valid", {31'd0, grant_valid}, 32'd1);
    chk("t6_regrant_id", {29'd0, grant_id}, 32'd2);
    flush();

    // Random traffic, occasional injected grants.
    for (int c = 0; c < 2000; c++) begin
      p  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
      fv = ($urandom_range(0, 1) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'($urandom);
      step(p, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), fv);
    end
    flush();
    @(negedge clk);
    #1;
    chk("end_grant_q_drained", grant_q.size(), 32'd0);
    chk("end_cyc_q_drained", cyc_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arb_req_sequencer.md
Name: arb_req_sequencer

Overview:
- Upstream/downstream companion to the 8-way combinational fixed-priority arbiter (req[0] highest priority).
- Captures single-cycle request pulses from clients into sticky pending bits and presents them as the arbiter's req vector.
- Registers the arbiter's one-hot gnt, issues a grant to the winning client, and holds the shared resource until service completes or a hold timeout fires.
- Serialises access so only one client owns the resource at a time.

Parameters:
- N, 8, number of requesters; must match the arbiter width.
- ID_W, 3, width of grant_id; equals clog2(N).
- MAX_HOLD, 16, maximum BUSY cycles before forced release; range 1..255.
- CNT_W, 8, hold counter width; must satisfy MAX_HOLD < 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_pulse  input  N  per-client request pulse; each asserted bit sets that client's pending bit.
- arb_req  output  N  pending vector, driven to the arbiter's req input.
- arb_gnt  input  N  one-hot grant from the combinational arbiter, sampled only in IDLE.
- svc_done  input  1  resource-finished pulse from the owning client/resource.
- grant_valid  output  1  one-cycle pulse when a new grant is issued.
- grant_id  output  ID_W  index of the current owner; held through GRANT and BUSY.
- grant_onehot  output  N  one-hot form of the owner; zero in IDLE.
- busy  output  1  high in GRANT and BUSY.
- timeout  output  1  one-cycle pulse on forced release.
- overflow  output  N  sticky; bit i sets if req_pulse[i] arrives while pending[i] is already 1.
- gnt_err  output  1  sticky; set if arb_gnt is sampled non-one-hot while arb_req != 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pending=0; all outputs 0; hold counter=0.
- Pending update each cycle: pending_next = (pending & ~clr) | req_pulse.
  - Set wins over clear on the same bit, so a new request is never lost.
  - arb_req = pending (registered), so a request appears one cycle after its pulse.
- State IDLE
  - If pending != 0 and arb_gnt is one-hot and arb_gnt is a subset of pending: latch owner = arb_gnt, clr = arb_gnt, then go to GRANT.
  - If pending != 0 and arb_gnt is zero, not one-hot, or outside pending: set gnt_err and stay in IDLE.
- State GRANT (exactly 1 cycle)
  - grant_valid=1; busy=1; hold counter cleared.
  - Next state is BUSY.
- State BUSY
  - busy=1; hold counter increments each cycle.
  - svc_done=1: go to IDLE; grant_onehot cleared on the transition.
  - Otherwise, if the counter reaches MAX_HOLD-1: pulse timeout, go to IDLE.
  - svc_done and timeout in the same cycle: svc_done takes priority and timeout stays 0.
  - svc_done seen in IDLE or GRANT is ignored.
- Latency: req_pulse at cycle t gives arb_req at t+1 and grant_valid at t+2, provided the block is idle and the client wins arbitration.
- Minimum IDLE dwell is one cycle between grants; the arbiter re-evaluates the updated pending vector in that cycle.
- While busy, arb_gnt is ignored and pending keeps accumulating.
- The released owner may re-request immediately; its new pulse re-sets its pending bit.
- overflow and gnt_err clear only on reset.
- Reset asserted mid-BUSY: immediate return to IDLE; the grant is dropped and no timeout pulse is produced.

Decomposition:
- Shared package arb_pkg holds:
  - N, ID_W, MAX_HOLD defaults;
  - the state enum (IDLE=2'd0, GRANT=2'd1, BUSY=2'd2);
  - a onehot-to-index function, also used by the arbiter's bench;
  - an is_onehot function.
- One natural sub-module, arb_hold_timer: counter with clear, enable and expiry flag, parameterised by MAX_HOLD.
- Pending register and FSM stay in the top module.
- Top-level bench instantiates arb_req_sequencer with the existing priority_arbiter_8 in the loop.

Test Plan:
1. Reset, then req_pulse=8'b1000_0000 at cycle 1 -> arb_req=8'h80 at cycle 2; grant_valid=1, grant_id=7, grant_onehot=8'h80 at cycle 3; busy=1 until svc_done.
2. Single-cycle req_pulse=8'hFF, svc_done 2 cycles after each grant -> grants issued in order 0,1,2…7; grant_valid pulses exactly 8 times; arb_req reaches 0 after the final grant.
3. Grant client 3, then withhold svc_done -> timeout pulses after exactly MAX_HOLD(16) BUSY cycles; busy drops the next cycle; pending[3] stays 0.
4. req_pulse[5] twice while pending[5]=1 -> overflow=8'b0010_0000; only one grant is issued to client 5.
5. Force arb_gnt=8'b0000_0011 with pending=8'h03 in IDLE -> gnt_err=1, no grant_valid, state stays IDLE.
6. rst_n dropped mid-BUSY (owner 2) -> busy, grant_onehot and pending clear asynchronously; timeout stays 0; after release, a fresh req_pulse[2] is granted normally.
